// File: rtl/count_cmd_pkg.sv
// Shared types and constants for the counter command front-end.
package count_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_STOP,
    CMD_START,
    CMD_UP,
    CMD_DOWN
  } cmd_e;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  localparam int unsigned NUM_BTN   = 4;
  localparam int unsigned BTN_STOP  = 0;
  localparam int unsigned BTN_START = 1;
  localparam int unsigned BTN_UP    = 2;
  localparam int unsigned BTN_DOWN  = 3;

  // Fixed priority: stop > start > up > down.
  function automatic cmd_e pick_cmd(input logic [NUM_BTN-1:0] pend);
    cmd_e sel;
    sel = CMD_NONE;
    if (pend[BTN_STOP])       sel = CMD_STOP;
    else if (pend[BTN_START]) sel = CMD_START;
    else if (pend[BTN_UP])    sel = CMD_UP;
    else if (pend[BTN_DOWN])  sel = CMD_DOWN;
    return sel;
  endfunction

endpackage

// File: rtl/count_cmd_sequencer_btn_debounce.sv
// Per-button 2-flop synchroniser, stability debounce and registered press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TMR_W           = 27
) (
  input  logic Clk100M,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [TMR_W-1:0] tmr;

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      press  <= 1'b0;
      tmr    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        tmr <= '0;
      end else if (tmr == TMR_LAST) begin
        // Accept the new level; only a 0->1 acceptance is a press.
        stable <= sync2;
        press  <= sync2;
        tmr    <= '0;
      end else begin
        tmr <= tmr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_cmd_sequencer.sv
// Button front-end: debounce, auto-repeat for up/down, and fixed-priority
// command arbiter driving single-cycle pulses to the counter.
module count_cmd_sequencer
  import count_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter int unsigned TMR_W           = 27
) (
  input  logic Clk100M,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_stop,
  input  logic btn_up,
  input  logic btn_down,
  output logic start,
  output logic stop,
  output logic up,
  output logic down,
  output logic cmd_drop
);

  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] ev;
  logic [NUM_BTN-1:0] iss;
  logic [NUM_BTN-1:0] clr;
  logic [NUM_BTN-1:0] merged;
  logic [NUM_BTN-1:0] pend_q;
  logic [NUM_BTN-1:0] pend_d;
  logic [1:0]         rpt_stable;
  logic [1:0]         rpt_press;
  logic [1:0]         rpt_ev;
  cmd_e               sel;

  assign raw[BTN_STOP]  = btn_stop;
  assign raw[BTN_START] = btn_start;
  assign raw[BTN_UP]    = btn_up;
  assign raw[BTN_DOWN]  = btn_down;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .TMR_W          (TMR_W)
    ) u_db (
      .Clk100M(Clk100M),
      .reset  (reset),
      .raw    (raw[g]),
      .stable (stable[g]),
      .press  (press[g])
    );
  end

  assign rpt_stable = {stable[BTN_DOWN], stable[BTN_UP]};
  assign rpt_press  = {press[BTN_DOWN], press[BTN_UP]};

  // Index 0 repeats up, index 1 repeats down.
  for (genvar r = 0; r < 2; r++) begin : g_rpt
    rpt_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             fire;

    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + 1'b1;
      fire    = 1'b0;
      if (!rpt_stable[r]) begin
        state_d = RPT_IDLE;
        tmr_d   = '0;
      end else begin
        case (state_q)
          RPT_IDLE: begin
            tmr_d = '0;
            if (rpt_press[r]) state_d = RPT_DELAY;
          end
          RPT_DELAY: begin
            if (tmr_q == DLY_LAST) begin
              fire    = 1'b1;
              state_d = RPT_REPEAT;
              tmr_d   = '0;
            end
          end
          RPT_REPEAT: begin
            if (tmr_q == PER_LAST) begin
              fire  = 1'b1;
              tmr_d = '0;
            end
          end
          default: begin
            state_d = RPT_IDLE;
            tmr_d   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge Clk100M) begin
      if (reset) begin
        state_q <= RPT_IDLE;
        tmr_q   <= '0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
      end
    end

    assign rpt_ev[r] = fire;
  end

  always_comb begin
    ev         = press;
    ev[BTN_UP]   = press[BTN_UP]   | rpt_ev[0];
    ev[BTN_DOWN] = press[BTN_DOWN] | rpt_ev[1];

    sel = pick_cmd(pend_q);
    iss = '0;
    case (sel)
      CMD_STOP:  iss[BTN_STOP]  = 1'b1;
      CMD_START: iss[BTN_START] = 1'b1;
      CMD_UP:    iss[BTN_UP]    = 1'b1;
      CMD_DOWN:  iss[BTN_DOWN]  = 1'b1;
      default:   iss = '0;
    endcase

    clr = iss;
    if (sel == CMD_STOP) begin
      clr[BTN_UP]   = 1'b1;
      clr[BTN_DOWN] = 1'b1;
    end

    // An event on a flag that stays pending this cycle is absorbed and lost;
    // an event on a flag being issued re-arms it.
    merged = ev & pend_q & ~iss;
    pend_d = (pend_q & ~clr) | (ev & ~merged);
  end

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      pend_q   <= '0;
      start    <= 1'b0;
      stop     <= 1'b0;
      up       <= 1'b0;
      down     <= 1'b0;
      cmd_drop <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      stop     <= (sel == CMD_STOP);
      start    <= (sel == CMD_START);
      up       <= (sel == CMD_UP);
      down     <= (sel == CMD_DOWN);
      cmd_drop <= |merged;
    end
  end

endmodule
